// File: rtl/riscv_ctrl_pkg.sv
// Control-path types and opcode constants for the 5-stage RV32I core.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_ctrl_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_HALT   = 7'b1110011;

  typedef enum logic [1:0] {
    ALU_OP_MEM    = 2'b00,
    ALU_OP_BRANCH = 2'b01,
    ALU_OP_RI     = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_SEL_ALU = 2'b00,
    WB_SEL_MEM = 2'b01,
    WB_SEL_PC4 = 2'b10,
    WB_SEL_IMM = 2'b11
  } wb_sel_e;

  // 18-bit stage control bundle, MSB first.
  typedef struct packed {
    logic       valid;
    logic       alu_src;
    alu_op_e    alu_op;
    logic       branch;
    logic       jump;
    logic       jalr_sel;
    logic       mem_read;
    logic       mem_write;
    wb_sel_e    wb_sel;
    logic       reg_write;
    logic       halt;
    logic [4:0] rd;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decoder.sv
// Opcode/rd to control bundle, plus source-register use and illegal flags.
// Latency: purely combinational.
// Backpressure: none; output follows the inputs every cycle.
module ctrl_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [4:0] rd,
  output ctrl_t      ctrl,
  output logic       rs1_used,
  output logic       rs2_used,
  output logic       illegal
);

  // Table decode; unlisted opcodes produce a bubble and raise illegal.
  always_comb begin
    ctrl       = CTRL_BUBBLE;
    rs1_used   = 1'b0;
    rs2_used   = 1'b0;
    illegal    = 1'b0;
    ctrl.valid = 1'b1;
    ctrl.rd    = rd;
    case (opcode)
      OPC_R: begin
        ctrl.alu_op    = ALU_OP_RI;
        ctrl.reg_write = 1'b1;
        rs1_used       = 1'b1;
        rs2_used       = 1'b1;
      end
      OPC_I: begin
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_OP_RI;
        ctrl.reg_write = 1'b1;
        rs1_used       = 1'b1;
      end
      OPC_LOAD: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.wb_sel    = WB_SEL_MEM;
        ctrl.reg_write = 1'b1;
        rs1_used       = 1'b1;
      end
      OPC_STORE: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        rs1_used       = 1'b1;
        rs2_used       = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl.alu_op = ALU_OP_BRANCH;
        ctrl.branch = 1'b1;
        rs1_used    = 1'b1;
        rs2_used    = 1'b1;
      end
      OPC_JAL: begin
        ctrl.jump      = 1'b1;
        ctrl.wb_sel    = WB_SEL_PC4;
        ctrl.reg_write = 1'b1;
      end
      OPC_JALR: begin
        ctrl.jump      = 1'b1;
        ctrl.jalr_sel  = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.wb_sel    = WB_SEL_PC4;
        ctrl.reg_write = 1'b1;
        rs1_used       = 1'b1;
      end
      OPC_LUI: begin
        ctrl.wb_sel    = WB_SEL_IMM;
        ctrl.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OPC_HALT: begin
        ctrl.halt = 1'b1;
      end
      default: begin
        ctrl    = CTRL_BUBBLE;
        illegal = 1'b1;
      end
    endcase
    // x0 is hardwired; never let a write to it reach the register file.
    if (rd == 5'd0) ctrl.reg_write = 1'b0;
  end

endmodule

// File: rtl/pipeline_control.sv
// Registered ID/EX/MEM/WB control path with load-use, redirect, illegal and HALT handling.
// Latency: ID at cycle N shows in ex_ctrl at N+1, mem_ctrl at N+2, wb_ctrl at N+3.
// Backpressure: only stall_if_id back to IF/ID; EX->MEM->WB always advance.
module pipeline_control
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W          = 32,
  parameter bit LOAD_USE_STALL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rd,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             ex_redirect,
  output ctrl_t            ex_ctrl,
  output ctrl_t            mem_ctrl,
  output ctrl_t            wb_ctrl,
  output logic             stall_if_id,
  output logic             flush_if_id,
  output logic             illegal,
  output logic             halted,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ctrl_t dec_ctrl;
  logic  dec_rs1_used;
  logic  dec_rs2_used;
  logic  dec_illegal;

  logic  halt_pending;
  logic  id_live;
  logic  rs_hit;
  logic  load_use;
  logic  illegal_now;
  logic  stall_cycle;
  ctrl_t ex_next;

  ctrl_decoder u_dec (
    .opcode   (id_opcode),
    .rd       (id_rd),
    .ctrl     (dec_ctrl),
    .rs1_used (dec_rs1_used),
    .rs2_used (dec_rs2_used),
    .illegal  (dec_illegal)
  );

  // Hazard detection and selection of what enters EX at the next edge.
  always_comb begin
    // Once HALT is in flight the ID slot is ignored entirely.
    id_live     = id_valid && !halt_pending;
    rs_hit      = (dec_rs1_used && (id_rs1 == ex_ctrl.rd)) ||
                  (dec_rs2_used && (id_rs2 == ex_ctrl.rd));
    load_use    = LOAD_USE_STALL && ex_ctrl.valid && ex_ctrl.mem_read &&
                  (ex_ctrl.rd != 5'd0) && id_live && rs_hit;
    // Redirect wins: the stalled instruction is being flushed anyway.
    stall_cycle = load_use && !ex_redirect;
    illegal_now = id_live && dec_illegal && !ex_redirect && !load_use;
    ex_next     = dec_ctrl;
    if (!id_live || ex_redirect || load_use || dec_illegal) ex_next = CTRL_BUBBLE;
    stall_if_id = !reset && (halt_pending || stall_cycle);
    flush_if_id = !reset && ex_redirect;
  end

  // Stage registers, illegal pulse and halt state.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_ctrl      <= CTRL_BUBBLE;
      mem_ctrl     <= CTRL_BUBBLE;
      wb_ctrl      <= CTRL_BUBBLE;
      illegal      <= 1'b0;
      halt_pending <= 1'b0;
      halted       <= 1'b0;
    end else begin
      ex_ctrl  <= ex_next;
      mem_ctrl <= ex_ctrl;
      wb_ctrl  <= mem_ctrl;
      illegal  <= illegal_now;
      if (ex_next.valid && ex_next.halt) halt_pending <= 1'b1;
      if (wb_ctrl.valid && wb_ctrl.halt) halted <= 1'b1;
    end
  end

  // Saturating retire and load-use stall counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (wb_ctrl.valid && (retired_cnt != '1)) retired_cnt <= retired_cnt + CNT_ONE;
      if (stall_cycle && (stall_cnt != '1))     stall_cnt   <= stall_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipeline_control.sv
// Scoreboard bench for pipeline_control: expected EX bundles queued at drive time, chained to MEM/WB.
// Latency: checks ex/mem/wb one, two and three cycles after the ID drive.
// Backpressure: stall/flush expectations supplied per step by the stimulus.
module tb_pipeline_control;
  import riscv_ctrl_pkg::*;

  localparam logic [6:0] R  = 7'b0110011, I  = 7'b0010011, LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011, BR = 7'b1100011, JL = 7'b1101111;
  localparam logic [6:0] JR = 7'b1100111, LU = 7'b0110111, AU = 7'b0010111;
  localparam logic [6:0] HT = 7'b1110011, BAD = 7'b1111111;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [6:0]  id_opcode;
  logic [4:0]  id_rd, id_rs1, id_rs2;
  logic        ex_redirect;
  ctrl_t       ex_ctrl, mem_ctrl, wb_ctrl;
  logic        stall_if_id, flush_if_id, illegal, halted;
  logic [31:0] retired_cnt, stall_cnt;
  ctrl_t       ex0, mem0, wb0;
  logic        stall0, flush0, illegal0, halted0;
  logic [31:0] retired0, stall_cnt0;

  int total = 0;
  int bad   = 0;

  logic [17:0] exp_q[$], mem_q[$], wb_q[$];
  int          exp_ret, exp_sc;
  logic        exp_halted, in_halt, ns_mode;

  always #5 clk = ~clk;

  pipeline_control #(.CNT_W(32), .LOAD_USE_STALL(1'b1)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_redirect(ex_redirect),
    .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
    .stall_if_id(stall_if_id), .flush_if_id(flush_if_id), .illegal(illegal),
    .halted(halted), .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
  );

  pipeline_control #(.CNT_W(32), .LOAD_USE_STALL(1'b0)) dut_nofwd (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_redirect(ex_redirect),
    .ex_ctrl(ex0), .mem_ctrl(mem0), .wb_ctrl(wb0),
    .stall_if_id(stall0), .flush_if_id(flush0), .illegal(illegal0),
    .halted(halted0), .retired_cnt(retired0), .stall_cnt(stall_cnt0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode table: {valid,alu_src,alu_op,branch,jump,jalr_sel,mem_read,mem_write,wb_sel,reg_write,halt}
  function automatic logic [17:0] ref_ctrl(input logic [6:0] op, input logic [4:0] rd);
    logic [12:0] f;
    case (op)
      R:       f = 13'b1_0_10_0_0_0_0_0_00_1_0;
      I:       f = 13'b1_1_10_0_0_0_0_0_00_1_0;
      LD:      f = 13'b1_1_00_0_0_0_1_0_01_1_0;
      ST:      f = 13'b1_1_00_0_0_0_0_1_00_0_0;
      BR:      f = 13'b1_0_01_1_0_0_0_0_00_0_0;
      JL:      f = 13'b1_0_00_0_1_0_0_0_10_1_0;
      JR:      f = 13'b1_1_00_0_1_1_0_0_10_1_0;
      LU:      f = 13'b1_0_00_0_0_0_0_0_11_1_0;
      AU:      f = 13'b1_1_00_0_0_0_0_0_00_1_0;
      HT:      f = 13'b1_0_00_0_0_0_0_0_00_0_1;
      default: f = 13'b0;
    endcase
    if (rd == 5'd0) f[1] = 1'b0;
    return (f == 13'b0) ? 18'd0 : {f, rd};
  endfunction

  // Called at posedge+1; returns at the next posedge+1.
  task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic redir,
                       input logic exp_bub, input logic exp_stall, input logic exp_flush,
                       input logic exp_ill);
    logic [17:0] e;
    id_valid = v; id_opcode = op; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2; ex_redirect = redir;
    #3;
    chk("stall_if_id", {31'd0, stall_if_id}, {31'd0, exp_stall});
    chk("flush_if_id", {31'd0, flush_if_id}, {31'd0, exp_flush});
    if (ns_mode) chk("nofwd_stall", {31'd0, stall0}, 32'd0);
    if (exp_stall && !in_halt) exp_sc++;
    exp_q.push_back(exp_bub ? 18'd0 : ref_ctrl(op, rd));
    @(posedge clk); #1;
    if (wb_q.size() == 0 || mem_q.size() == 0 || exp_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = wb_q.pop_front();
      chk("wb_ctrl", {14'd0, wb_ctrl}, {14'd0, e});
      chk("halted", {31'd0, halted}, {31'd0, exp_halted});
      chk("retired_cnt", retired_cnt, exp_ret);
      if (e[17]) exp_ret++;
      if (e[17] && e[5]) exp_halted = 1'b1;
      e = mem_q.pop_front();
      chk("mem_ctrl", {14'd0, mem_ctrl}, {14'd0, e});
      wb_q.push_back(e);
      e = exp_q.pop_front();
      chk("ex_ctrl", {14'd0, ex_ctrl}, {14'd0, e});
      mem_q.push_back(e);
    end
    chk("illegal", {31'd0, illegal}, {31'd0, exp_ill});
    chk("stall_cnt", stall_cnt, exp_sc);
    if (ns_mode) chk("nofwd_ex", {14'd0, ex0}, {14'd0, v ? ref_ctrl(op, rd) : 18'd0});
  endtask

  // Two reset cycles with a LOAD at ID and a redirect asserted: stall/flush must stay low.
  task automatic do_reset();
    reset = 1'b1; id_valid = 1'b1; id_opcode = LD; id_rd = 5'd5;
    id_rs1 = 5'd5; id_rs2 = 5'd5; ex_redirect = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #3;
      chk("rst_stall", {31'd0, stall_if_id}, 32'd0);
      chk("rst_flush", {31'd0, flush_if_id}, 32'd0);
      @(posedge clk); #1;
    end
    chk("rst_ex",  {14'd0, ex_ctrl},  32'd0);
    chk("rst_mem", {14'd0, mem_ctrl}, 32'd0);
    chk("rst_wb",  {14'd0, wb_ctrl},  32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_halted",  {31'd0, halted},  32'd0);
    chk("rst_retired", retired_cnt, 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    reset = 1'b0; id_valid = 1'b0; ex_redirect = 1'b0;
    exp_q.delete(); mem_q.delete(); wb_q.delete();
    mem_q.push_back(18'd0); wb_q.push_back(18'd0);
    exp_ret = 0; exp_sc = 0; exp_halted = 1'b0; in_halt = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    ns_mode = 1'b0; in_halt = 1'b0;
    reset = 1'b1; id_valid = 1'b0; id_opcode = '0; id_rd = '0; id_rs1 = '0; id_rs2 = '0;
    ex_redirect = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Decode stream, one per cycle (v, op, rd, rs1, rs2, redir, bub, stall, flush, ill)
    drive(1, R,  5'd3,  5'd1, 5'd2, 0, 0, 0, 0, 0);
    drive(1, I,  5'd4,  5'd3, 5'd0, 0, 0, 0, 0, 0);
    drive(1, LD, 5'd5,  5'd4, 5'd0, 0, 0, 0, 0, 0);
    drive(1, ST, 5'd9,  5'd6, 5'd7, 0, 0, 0, 0, 0);
    drive(1, BR, 5'd8,  5'd1, 5'd2, 0, 0, 0, 0, 0);
    drive(1, JL, 5'd1,  5'd0, 5'd0, 0, 0, 0, 0, 0);
    drive(1, LU, 5'd7,  5'd0, 5'd0, 0, 0, 0, 0, 0);
    drive(1, R,  5'd0,  5'd1, 5'd2, 0, 0, 0, 0, 0);
    drive(1, AU, 5'd10, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    drive(1, JR, 5'd11, 5'd2, 5'd0, 0, 0, 0, 0, 0);

    // Load-use on rs1: one stall cycle, then the held ADD proceeds
    drive(1, LD, 5'd5, 5'd1, 5'd0, 0, 0, 0, 0, 0);
    drive(1, R,  5'd6, 5'd5, 5'd1, 0, 1, 1, 0, 0);
    drive(1, R,  5'd6, 5'd5, 5'd1, 0, 0, 0, 0, 0);
    // Load-use on rs2 of a store
    drive(1, LD, 5'd5, 5'd1, 5'd0, 0, 0, 0, 0, 0);
    drive(1, ST, 5'd2, 5'd1, 5'd5, 0, 1, 1, 0, 0);
    drive(1, ST, 5'd2, 5'd1, 5'd5, 0, 0, 0, 0, 0);
    // Load to x0 never interlocks; LUI does not read rs1
    drive(1, LD, 5'd0, 5'd1, 5'd0, 0, 0, 0, 0, 0);
    drive(1, R,  5'd6, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    drive(1, LD, 5'd5, 5'd1, 5'd0, 0, 0, 0, 0, 0);
    drive(1, LU, 5'd3, 5'd5, 5'd5, 0, 0, 0, 0, 0);

    // Redirect: BEQ in EX flushes the ADD behind it
    drive(1, BR, 5'd0, 5'd1, 5'd2, 0, 0, 0, 0, 0);
    drive(1, R,  5'd3, 5'd1, 5'd2, 1, 1, 0, 1, 0);
    // Redirect overrides a simultaneous load-use stall
    drive(1, LD, 5'd5, 5'd1, 5'd0, 0, 0, 0, 0, 0);
    drive(1, R,  5'd6, 5'd5, 5'd1, 1, 1, 0, 1, 0);
    drive(1, R,  5'd6, 5'd5, 5'd1, 0, 0, 0, 0, 0);

    // Illegal: one-cycle pulse; suppressed under redirect or when ID is empty
    drive(1, BAD, 5'd3, 5'd0, 5'd0, 0, 1, 0, 0, 1);
    drive(1, R,   5'd3, 5'd1, 5'd2, 0, 0, 0, 0, 0);
    drive(1, BAD, 5'd3, 5'd0, 5'd0, 1, 1, 0, 1, 0);
    drive(0, BAD, 5'd3, 5'd0, 5'd0, 0, 1, 0, 0, 0);
    drive(0, R,   5'd3, 5'd1, 5'd2, 0, 1, 0, 0, 0);
    drive(1, R,   5'd3, 5'd1, 5'd2, 0, 0, 0, 0, 0);

    // Reset while a load sits in EX (stall condition live) and redirect is asserted
    drive(1, LD, 5'd5, 5'd1, 5'd0, 0, 0, 0, 0, 0);
    do_reset();

    // Build without the interlock: no stall on the same load-use pair
    ns_mode = 1'b1;
    drive(1, LD, 5'd5, 5'd1, 5'd0, 0, 0, 0, 0, 0);
    drive(1, R,  5'd6, 5'd5, 5'd1, 0, 1, 1, 0, 0);
    ns_mode = 1'b0;
    chk("nofwd_mem", {14'd0, mem0}, {14'd0, ref_ctrl(LD, 5'd5)});
    chk("nofwd_wb",  {14'd0, wb0}, 32'd0);
    chk("nofwd_flush", {31'd0, flush0}, 32'd0);
    chk("nofwd_illegal", {31'd0, illegal0}, 32'd0);
    chk("nofwd_halted", {31'd0, halted0}, 32'd0);
    chk("nofwd_retired", retired0, 32'd0);
    chk("nofwd_stall_cnt", stall_cnt0, 32'd0);

    // HALT at ID (cycle N); ID ignored and held from N+1; halted from N+4; reset at N+6
    do_reset();
    drive(1, R,  5'd3, 5'd1, 5'd2, 0, 0, 0, 0, 0);
    drive(1, HT, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    in_halt = 1'b1;
    for (int k = 0; k < 5; k++) drive(1, R, 5'd4, 5'd1, 5'd2, 0, 1, 1, 0, 0);
    chk("halt_sticky", {31'd0, halted}, 32'd1);
    chk("halt_retired", retired_cnt, 32'd2);
    do_reset();
    drive(1, R, 5'd4, 5'd1, 5'd2, 0, 0, 0, 0, 0);
    drive(1, I, 5'd6, 5'd4, 5'd0, 0, 0, 0, 0, 0);
    drive(0, R, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0);
    drive(0, R, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0);
    drive(0, R, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
